// File: rtl/seg_pkg.sv
// Shared segment constants, hex decode function and scan phase type.
package seg_pkg;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is lit on A-F to mark letters
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h08;
    localparam logic [7:0] SEG_B     = 8'h00;
    localparam logic [7:0] SEG_C     = 8'h46;
    localparam logic [7:0] SEG_D     = 8'h40;
    localparam logic [7:0] SEG_E     = 8'h06;
    localparam logic [7:0] SEG_F     = 8'h0E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef logic [1:0] scan_phase_t;

    // Nibble to active-low segment pattern
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational digit pattern: decoded nibble with optional forced dp, blank when not visible.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       visible,
    output logic [7:0] seg_c
);

    // Forced dp clears bit 7 (active-low); invisible digits drive all segments off
    always_comb begin
        seg_c = SEG_BLANK;
        if (visible) begin
            seg_c = hex_to_seg(nibble) & ~{dp, 7'b000_0000};
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit two-bus 7-segment scan driver with frame snapshot, anti-ghost blank gap and blink.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYC    = 100,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic        sys_clk_in,
    input  logic        sys_rst_n,
    input  logic        disp_en,
    input  logic [31:0] digit_data,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_en,
    input  logic [7:0]  blink_en,
    output logic [7:0]  seg_cs_pin,
    output logic [7:0]  seg_data_0_pin,
    output logic [7:0]  seg_data_1_pin,
    output logic        frame_start
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] div_cnt;
    scan_phase_t      phase;
    logic             first_q;
    logic [31:0]      data_snap;
    logic [7:0]       en_snap;
    logic [7:0]       dp_snap;
    logic [7:0]       blink_snap;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_off;

    logic             div_wrap_c;
    logic             frame_wrap_c;
    logic             snap_take_c;
    logic             active_c;
    logic [2:0]       idx_lo_c;
    logic [2:0]       idx_hi_c;
    logic             vis_lo_c;
    logic             vis_hi_c;
    logic [3:0]       nib_lo_c;
    logic [3:0]       nib_hi_c;
    logic [7:0]       cs_c;
    logic [7:0]       seg_lo_c;
    logic [7:0]       seg_hi_c;

    // Scan timing, digit selection and visibility for the current (div_cnt, phase)
    always_comb begin
        idx_lo_c     = {1'b0, phase};
        idx_hi_c     = {1'b1, phase};
        div_wrap_c   = (div_cnt == DIV_LAST);
        frame_wrap_c = div_wrap_c && (phase == 2'd3);
        snap_take_c  = first_q || frame_wrap_c;
        active_c     = disp_en && (div_cnt >= BLANK_END);
        vis_lo_c     = active_c && en_snap[idx_lo_c] && !(blink_off && blink_snap[idx_lo_c]);
        vis_hi_c     = active_c && en_snap[idx_hi_c] && !(blink_off && blink_snap[idx_hi_c]);
        nib_lo_c     = data_snap[{idx_lo_c, 2'b00} +: 4];
        nib_hi_c     = data_snap[{idx_hi_c, 2'b00} +: 4];
        cs_c           = 8'h00;
        cs_c[idx_lo_c] = vis_lo_c;
        cs_c[idx_hi_c] = vis_hi_c;
    end

    // Divider and phase counter; held during the post-reset snapshot cycle so frame 0 starts aligned
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
            phase   <= 2'd0;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (!first_q) begin
                if (div_wrap_c) begin
                    div_cnt <= '0;
                    phase   <= phase + 2'd1;
                end else begin
                    div_cnt <= div_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Frame snapshot of all display inputs, with frame_start marking the capture
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_snap   <= 32'h0000_0000;
            en_snap     <= 8'h00;
            dp_snap     <= 8'h00;
            blink_snap  <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap_take_c;
            if (snap_take_c) begin
                data_snap  <= digit_data;
                en_snap    <= digit_en;
                dp_snap    <= dp_en;
                blink_snap <= blink_en;
            end
        end
    end

    // Blink half-period counter: counts completed frames, toggles blink_off on wrap
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (frame_wrap_c) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                blink_off <= !blink_off;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    seg_hex_decode u_dec_lo (
        .nibble  (nib_lo_c),
        .dp      (dp_snap[idx_lo_c]),
        .visible (vis_lo_c),
        .seg_c   (seg_lo_c)
    );

    seg_hex_decode u_dec_hi (
        .nibble  (nib_hi_c),
        .dp      (dp_snap[idx_hi_c]),
        .visible (vis_hi_c),
        .seg_c   (seg_hi_c)
    );

    // Registered pin drivers; reset forces all digits dark immediately
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg_cs_pin     <= 8'h00;
            seg_data_0_pin <= SEG_BLANK;
            seg_data_1_pin <= SEG_BLANK;
        end else begin
            seg_cs_pin     <= cs_c;
            seg_data_0_pin <= seg_lo_c;
            seg_data_1_pin <= seg_hi_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=1, BLINK_FRAMES=2.
module tb_seg_scan_driver;

    logic        sys_clk_in;
    logic        sys_rst_n;
    logic        disp_en;
    logic [31:0] digit_data;
    logic [7:0]  digit_en;
    logic [7:0]  dp_en;
    logic [7:0]  blink_en;
    logic [7:0]  seg_cs_pin;
    logic [7:0]  seg_data_0_pin;
    logic [7:0]  seg_data_1_pin;
    logic        frame_start;

    int n_assert = 0;
    int n_fail   = 0;

    seg_scan_driver #(
        .SCAN_DIV     (8),
        .BLANK_CYC    (1),
        .BLINK_FRAMES (2)
    ) dut (
        .sys_clk_in     (sys_clk_in),
        .sys_rst_n      (sys_rst_n),
        .disp_en        (disp_en),
        .digit_data     (digit_data),
        .digit_en       (digit_en),
        .dp_en          (dp_en),
        .blink_en       (blink_en),
        .seg_cs_pin     (seg_cs_pin),
        .seg_data_0_pin (seg_data_0_pin),
        .seg_data_1_pin (seg_data_1_pin),
        .frame_start    (frame_start)
    );

    initial begin
        sys_clk_in = 1'b0;
        forever #5 sys_clk_in = ~sys_clk_in;
    end

    // One clock, ending on the falling edge where outputs are sampled
    task automatic tick();
        @(posedge sys_clk_in);
        @(negedge sys_clk_in);
    endtask

    // Compare {frame_start, cs, data_0, data_1} against the expected vector
    task automatic chk(input string tag, input logic [24:0] exp);
        logic [24:0] obs;
        obs = {frame_start, seg_cs_pin, seg_data_0_pin, seg_data_1_pin};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed fs/cs/d0/d1=%h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the next frame_start pulse
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        n_assert++;
        assert (frame_start === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: frame_start observed %b expected 1 within 40 clk", tag, frame_start);
        end
    endtask

    // Check a whole frame starting from a frame_start sample; ends on the next frame_start
    task automatic check_frame(input string tag, input logic [31:0] cs4,
                               input logic [31:0] d04, input logic [31:0] d14);
        for (int p = 0; p < 4; p++) begin
            tick();
            chk($sformatf("%s p%0d gap", tag, p), {1'b0, 8'h00, 8'hFF, 8'hFF});
            tick();
            chk($sformatf("%s p%0d first", tag, p),
                {1'b0, cs4[8*p +: 8], d04[8*p +: 8], d14[8*p +: 8]});
            repeat (6) tick();
            chk($sformatf("%s p%0d last", tag, p),
                {(p == 3), cs4[8*p +: 8], d04[8*p +: 8], d14[8*p +: 8]});
        end
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        disp_en    = 1'b1;
        digit_data = 32'h7654_3210;
        digit_en   = 8'hFF;
        dp_en      = 8'h00;
        blink_en   = 8'h00;
        tick();
        tick();
        chk("reset", {1'b0, 8'h00, 8'hFF, 8'hFF});

        // 1: basic scan of 0..7
        sys_rst_n = 1'b1;
        wait_frame("t1 start");
        // 2: new data plus dp on digit 0, applied after the snapshot -> next frame
        digit_data = 32'hFEDC_BA98;
        dp_en      = 8'h01;
        check_frame("t1", 32'h8844_2211, 32'hB0A4_F9C0, 32'hF882_9299);
        check_frame("t2", 32'h8844_2211, 32'h0008_9000, 32'h0E06_4046);

        // 3: mid-frame change (phase 1) keeps old values until the next frame
        repeat (10) tick();
        digit_data = 32'h3333_3333;
        dp_en      = 8'h00;
        tick();
        chk("t3 mid-frame hold", {1'b0, 8'h22, 8'h90, 8'h40});
        wait_frame("t3 next frame");
        check_frame("t3", 32'h8844_2211, 32'hB0B0_B0B0, 32'hB0B0_B0B0);

        // 4: high digits disabled, then disp_en pulsed low mid-phase
        digit_en   = 8'h0F;
        digit_data = 32'h7654_3210;
        wait_frame("t4 next frame");
        check_frame("t4", 32'h0804_0201, 32'hB0A4_F9C0, 32'hFFFF_FFFF);
        repeat (2) tick();
        chk("t4 lit before off", {1'b0, 8'h01, 8'hC0, 8'hFF});
        disp_en = 1'b0;
        tick();
        chk("t4 disp off", {1'b0, 8'h00, 8'hFF, 8'hFF});
        disp_en = 1'b1;
        tick();
        chk("t4 disp back on", {1'b0, 8'h01, 8'hC0, 8'hFF});
        repeat (28) tick();
        chk("t4 frame timing kept", {1'b1, 8'h08, 8'hB0, 8'hFF});

        // 5: blink digit 0; frames counted from reset
        sys_rst_n  = 1'b0;
        digit_en   = 8'hFF;
        blink_en   = 8'h01;
        #1;
        chk("t5 reset", {1'b0, 8'h00, 8'hFF, 8'hFF});
        tick();
        tick();
        sys_rst_n = 1'b1;
        wait_frame("t5 start");
        for (int f = 0; f < 6; f++) begin
            if (f == 2 || f == 3)
                check_frame($sformatf("t5 f%0d", f), 32'h8844_2210, 32'hB0A4_F9FF, 32'hF882_9299);
            else
                check_frame($sformatf("t5 f%0d", f), 32'h8844_2211, 32'hB0A4_F9C0, 32'hF882_9299);
        end

        // 6: async reset in phase 2, then restart at phase 0
        repeat (20) tick();
        chk("t6 phase2 lit", {1'b0, 8'h44, 8'hA4, 8'h82});
        sys_rst_n = 1'b0;
        #1;
        chk("t6 async reset", {1'b0, 8'h00, 8'hFF, 8'hFF});
        tick();
        tick();
        chk("t6 held reset", {1'b0, 8'h00, 8'hFF, 8'hFF});
        sys_rst_n = 1'b1;
        tick();
        chk("t6 first frame_start", {1'b1, 8'h00, 8'hFF, 8'hFF});
        check_frame("t6", 32'h8844_2211, 32'hB0A4_F9C0, 32'hF882_9299);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
